// File: rtl/ant_symbol_pingpong_buf.sv
// Two-bank ping-pong buffer for one OFDM symbol of per-antenna IQ, read out through a 2-entry skid.
// Define SYMBUF_OVF_CNT_EN to build the saturating overflow event counter on o_ovf_cnt.
module ant_symbol_pingpong_buf #(
   parameter int ANT    = 4,
   parameter int RE_NUM = 1584
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [10:0]         i_iq_addr,
   input  logic [ANT*32-1:0]   i_iq_data,
   input  logic                i_iq_vld,
   input  logic                i_iq_last,
   input  logic                i_rd_ready,
   output logic [ANT*32-1:0]   o_rd_data,
   output logic [10:0]         o_rd_addr,
   output logic                o_rd_vld,
   output logic                o_rd_last,
   output logic [1:0]          o_bank_full,
   output logic                o_overflow,
   output logic [15:0]         o_ovf_cnt
);

   localparam int          W         = ANT * 32;
   localparam logic [10:0] LAST_ADDR = 11'(RE_NUM - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_e;

   logic [W-1:0] mem_q [2][RE_NUM];
   logic [W-1:0] ram_data_q;
   logic [10:0]  ram_addr_q;
   logic         ram_vld_q;

   logic         wbank_q, wbank_d;
   logic [1:0]   full_q, full_d;
   logic         ovf_q, ovf_d;
   rd_state_e    state_q, state_d;
   logic         rbank_q, rbank_d;
   logic [10:0]  raddr_q, raddr_d;

   logic [1:0]   cnt_q, cnt_d;
   logic [W-1:0] s0_data_q, s0_data_d, s1_data_q, s1_data_d;
   logic [10:0]  s0_addr_q, s0_addr_d, s1_addr_q, s1_addr_d;

   logic         wr_en, rd_en, pop, clr_en;
   logic         other_full, cur_full;
   logic [2:0]   occ;

   assign wr_en  = i_iq_vld && (i_iq_addr < 11'(RE_NUM)) && !i_reset;
   assign clr_en = (state_q == DONE);
   assign pop    = o_rd_vld && i_rd_ready;

   // A bank being released by DONE this cycle already counts as free to the write side.
   assign other_full = full_q[~wbank_q] && !(clr_en && (rbank_q == ~wbank_q));
   assign cur_full   = full_q[wbank_q]  && !(clr_en && (rbank_q == wbank_q));

   // Beats that will sit in the skid next cycle; a new read needs one free slot on top.
   assign occ   = {1'b0, cnt_q} + {2'b00, ram_vld_q} - {2'b00, pop};
   assign rd_en = (state_q == READ) && (occ < 3'd2);

   always_ff @(posedge i_clk) begin
      if (wr_en) mem_q[wbank_q][i_iq_addr] <= i_iq_data;
      if (rd_en) begin
         ram_data_q <= mem_q[rbank_q][raddr_q];
         ram_addr_q <= raddr_q;
      end
   end

   always_comb begin
      full_d  = full_q;
      wbank_d = wbank_q;
      ovf_d   = ovf_q;
      if (clr_en) full_d[rbank_q] = 1'b0;
      if (i_iq_last) begin
         full_d[wbank_q] = 1'b1;
         if (!other_full) wbank_d = ~wbank_q;
         else if (cur_full) ovf_d = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      rbank_d = rbank_q;
      raddr_d = raddr_q;
      case (state_q)
         IDLE: begin
            if (|full_q) begin
               state_d = READ;
               raddr_d = '0;
               rbank_d = (&full_q) ? ~wbank_q : full_q[1];
            end
         end
         READ: begin
            if (rd_en) begin
               raddr_d = raddr_q + 11'd1;
               if (raddr_q == LAST_ADDR) state_d = DRAIN;
            end
         end
         DRAIN:   if (pop && o_rd_last) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      s0_data_d = s0_data_q;
      s0_addr_d = s0_addr_q;
      s1_data_d = s1_data_q;
      s1_addr_d = s1_addr_q;
      case (cnt_q)
         2'd0: begin
            if (ram_vld_q) begin
               s0_data_d = ram_data_q;
               s0_addr_d = ram_addr_q;
               cnt_d     = 2'd1;
            end
         end
         2'd1: begin
            if (ram_vld_q && pop) begin
               s0_data_d = ram_data_q;
               s0_addr_d = ram_addr_q;
            end else if (ram_vld_q) begin
               s1_data_d = ram_data_q;
               s1_addr_d = ram_addr_q;
               cnt_d     = 2'd2;
            end else if (pop) begin
               cnt_d = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               s0_data_d = s1_data_q;
               s0_addr_d = s1_addr_q;
               if (ram_vld_q) begin
                  s1_data_d = ram_data_q;
                  s1_addr_d = ram_addr_q;
               end else begin
                  cnt_d = 2'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wbank_q   <= 1'b0;
         full_q    <= '0;
         ovf_q     <= 1'b0;
         state_q   <= IDLE;
         rbank_q   <= 1'b0;
         raddr_q   <= '0;
         ram_vld_q <= 1'b0;
         cnt_q     <= '0;
         s0_data_q <= '0;
         s0_addr_q <= '0;
         s1_data_q <= '0;
         s1_addr_q <= '0;
      end else begin
         wbank_q   <= wbank_d;
         full_q    <= full_d;
         ovf_q     <= ovf_d;
         state_q   <= state_d;
         rbank_q   <= rbank_d;
         raddr_q   <= raddr_d;
         ram_vld_q <= rd_en;
         cnt_q     <= cnt_d;
         s0_data_q <= s0_data_d;
         s0_addr_q <= s0_addr_d;
         s1_data_q <= s1_data_d;
         s1_addr_q <= s1_addr_d;
      end
   end

   assign o_rd_vld    = (cnt_q != 2'd0);
   assign o_rd_data   = s0_data_q;
   assign o_rd_addr   = s0_addr_q;
   assign o_rd_last   = o_rd_vld && (s0_addr_q == LAST_ADDR);
   assign o_bank_full = full_q;
   assign o_overflow  = ovf_q;

`ifdef SYMBUF_OVF_CNT_EN
   logic [15:0] ovf_cnt_q;
   logic        ovf_evt;

   assign ovf_evt = i_iq_last && other_full && cur_full;

   always_ff @(posedge i_clk) begin
      if (i_reset)                             ovf_cnt_q <= '0;
      else if (ovf_evt && (ovf_cnt_q != '1))   ovf_cnt_q <= ovf_cnt_q + 16'd1;
   end

   assign o_ovf_cnt = ovf_cnt_q;
`else
   assign o_ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_ant_symbol_pingpong_buf.sv
// Directed bench for ant_symbol_pingpong_buf: table of single-symbol round trips plus
// hand sequences for overflow, write-complete coinciding with DONE, and reset mid-read.
module tb_ant_symbol_pingpong_buf;
   localparam int ANT    = 4;
   localparam int RE_NUM = 1584;
   localparam int W      = ANT * 32;
`ifdef SYMBUF_OVF_CNT_EN
   localparam logic [15:0] EXP_CNT1 = 16'd1;
`else
   localparam logic [15:0] EXP_CNT1 = 16'd0;
`endif

   logic          clk = 1'b0;
   logic          i_reset = 1'b1;
   logic [10:0]   i_iq_addr = '0;
   logic [W-1:0]  i_iq_data = '0;
   logic          i_iq_vld = 1'b0;
   logic          i_iq_last = 1'b0;
   logic          i_rd_ready = 1'b0;
   logic [W-1:0]  o_rd_data;
   logic [10:0]   o_rd_addr;
   logic          o_rd_vld, o_rd_last;
   logic [1:0]    o_bank_full;
   logic          o_overflow;
   logic [15:0]   o_ovf_cnt;

   always #5 clk = ~clk;

   ant_symbol_pingpong_buf #(.ANT(ANT), .RE_NUM(RE_NUM)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_iq_addr(i_iq_addr), .i_iq_data(i_iq_data),
      .i_iq_vld(i_iq_vld), .i_iq_last(i_iq_last), .i_rd_ready(i_rd_ready),
      .o_rd_data(o_rd_data), .o_rd_addr(o_rd_addr), .o_rd_vld(o_rd_vld), .o_rd_last(o_rd_last),
      .o_bank_full(o_bank_full), .o_overflow(o_overflow), .o_ovf_cnt(o_ovf_cnt)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_mode = 3;
   int exp_q[$];
   int beat_idx = 0;
   int syms_done = 0;

   typedef struct {
      int         sym;
      int         mode;
      logic [1:0] exp_full;
      int         exp_lat;
   } vec_t;

   function automatic logic [W-1:0] mk(input int sym, input int a);
      logic [W-1:0] r;
      for (int k = 0; k < ANT; k++) r[k*32 +: 32] = {8'(sym), 8'(k), 5'd0, 11'(a)};
      return r;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Modes: 0 always ready, 1 toggle, 2 two-of-three, 3 never ready.
   function automatic logic ready_for(input int m, input int c);
      case (m)
         0:       return 1'b1;
         1:       return c[0];
         2:       return (c % 3) != 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
      i_rd_ready = ready_for(rd_mode, cyc);
   endtask

   task automatic set_mode(input int m);
      rd_mode    = m;
      i_rd_ready = ready_for(m, cyc);
   endtask

   task automatic write_symbol(input int sym);
      for (int a = 0; a < RE_NUM; a++) begin
         i_iq_vld  = 1'b1;
         i_iq_addr = 11'(a);
         i_iq_data = mk(sym, a);
         tick;
      end
      i_iq_vld = 1'b0;
   endtask

   task automatic pulse_last;
      i_iq_vld  = 1'b0;
      i_iq_last = 1'b1;
      tick;
      i_iq_last = 1'b0;
   endtask

   task automatic wait_reads(input int target);
      int n = 0;
      while (syms_done < target && n < 6 * RE_NUM) begin
         tick;
         n++;
      end
      chk("read_timeout", W'(syms_done >= target), W'(1));
   endtask

   task automatic do_reset;
      set_mode(3);
      i_reset = 1'b1;
      tick;
      i_reset = 1'b0;
      exp_q.delete();
      beat_idx = 0;
   endtask

   // Beat scoreboard and stall-stability monitor, sampled on the falling edge.
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data;
   logic [10:0]  prev_addr;
   logic         prev_last;

   initial begin
      forever begin
         @(negedge clk);
         if (i_reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_vld",  W'(o_rd_vld),  W'(1));
               chk("stall_addr", W'(o_rd_addr), W'(prev_addr));
               chk("stall_data", o_rd_data,     prev_data);
               chk("stall_last", W'(o_rd_last), W'(prev_last));
            end
            if (o_rd_vld && i_rd_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got addr %0d expected no beat", o_rd_addr);
               end else begin
                  chk("rd_addr", W'(o_rd_addr), W'(beat_idx));
                  chk("rd_data", o_rd_data, mk(exp_q[0], beat_idx));
                  chk("rd_last", W'(o_rd_last), W'(beat_idx == RE_NUM - 1));
                  beat_idx++;
                  if (beat_idx == RE_NUM) begin
                     beat_idx = 0;
                     void'(exp_q.pop_front());
                     syms_done++;
                  end
               end
            end
            prev_stall = o_rd_vld && !i_rd_ready;
            prev_data  = o_rd_data;
            prev_addr  = o_rd_addr;
            prev_last  = o_rd_last;
         end
      end
   end

   initial begin
      vec_t tbl[4];
      int   lat, target, cyc0, n;

      tbl[0] = '{sym: 0, mode: 0, exp_full: 2'b01, exp_lat: 3};
      tbl[1] = '{sym: 1, mode: 1, exp_full: 2'b10, exp_lat: 3};
      tbl[2] = '{sym: 2, mode: 2, exp_full: 2'b01, exp_lat: 3};
      tbl[3] = '{sym: 3, mode: 0, exp_full: 2'b10, exp_lat: 3};

      set_mode(3);
      tick;
      tick;
      chk("rst_vld",  W'(o_rd_vld),    W'(0));
      chk("rst_last", W'(o_rd_last),   W'(0));
      chk("rst_addr", W'(o_rd_addr),   W'(0));
      chk("rst_data", o_rd_data,       '0);
      chk("rst_full", W'(o_bank_full), W'(0));
      chk("rst_ovf",  W'(o_overflow),  W'(0));
      chk("rst_cnt",  W'(o_ovf_cnt),   W'(0));
      i_reset = 1'b0;
      tick;

      for (int i = 0; i < 4; i++) begin
         set_mode(tbl[i].mode);
         exp_q.push_back(tbl[i].sym);
         target = syms_done + 1;
         write_symbol(tbl[i].sym);
         pulse_last;
         chk("full_after_last", W'(o_bank_full), W'(tbl[i].exp_full));
         lat = 0;
         while (!o_rd_vld && lat < 20) begin
            tick;
            lat++;
         end
         chk("first_vld_latency", W'(lat), W'(tbl[i].exp_lat));
         cyc0 = cyc;
         wait_reads(target);
         if (tbl[i].mode == 0) chk("burst_cycles", W'(cyc - cyc0), W'(RE_NUM));
         tick;
         chk("full_after_read", W'(o_bank_full), W'(0));
         chk("no_ovf", W'(o_overflow), W'(0));
      end

      // Three symbols with the reader stalled: the third overwrites bank 1.
      do_reset;
      write_symbol(10);
      pulse_last;
      chk("ovf_full1", W'(o_bank_full), W'(2'b01));
      write_symbol(11);
      pulse_last;
      chk("ovf_full2", W'(o_bank_full), W'(2'b11));
      chk("ovf_not_yet", W'(o_overflow), W'(0));
      write_symbol(12);
      pulse_last;
      chk("ovf_flag", W'(o_overflow), W'(1));
      chk("ovf_cnt",  W'(o_ovf_cnt),  W'(EXP_CNT1));
      chk("ovf_full3", W'(o_bank_full), W'(2'b11));
      exp_q.push_back(10);
      exp_q.push_back(12);
      target = syms_done + 2;
      set_mode(0);
      wait_reads(target);
      tick;
      chk("ovf_full_drained", W'(o_bank_full), W'(0));
      chk("ovf_sticky", W'(o_overflow), W'(1));

      // i_iq_last lands in the DONE cycle of the other bank.
      do_reset;
      set_mode(0);
      exp_q.push_back(20);
      target = syms_done + 1;
      write_symbol(20);
      pulse_last;
      exp_q.push_back(21);
      write_symbol(21);
      n = 0;
      while (syms_done < target && n < 4 * RE_NUM) begin
         tick;
         n++;
      end
      pulse_last;
      chk("coinc_full", W'(o_bank_full), W'(2'b10));
      chk("coinc_no_ovf", W'(o_overflow), W'(0));
      chk("coinc_cnt", W'(o_ovf_cnt), W'(0));
      wait_reads(target + 1);
      tick;
      chk("coinc_drained", W'(o_bank_full), W'(0));
      exp_q.push_back(22);
      write_symbol(22);
      pulse_last;
      chk("coinc_wbank_toggled", W'(o_bank_full), W'(2'b01));
      wait_reads(target + 2);
      tick;

      // Reset during a read burst, then a fresh symbol through bank 0.
      do_reset;
      set_mode(0);
      exp_q.push_back(30);
      write_symbol(30);
      pulse_last;
      n = 0;
      while (beat_idx < 700 && n < 4 * RE_NUM) begin
         tick;
         n++;
      end
      chk("midrd_reached_700", W'(beat_idx), W'(700));
      set_mode(3);
      i_reset = 1'b1;
      tick;
      chk("midrd_vld",  W'(o_rd_vld),    W'(0));
      chk("midrd_full", W'(o_bank_full), W'(0));
      chk("midrd_addr", W'(o_rd_addr),   W'(0));
      chk("midrd_data", o_rd_data,       '0);
      i_reset = 1'b0;
      exp_q.delete();
      beat_idx = 0;
      set_mode(1);
      exp_q.push_back(31);
      target = syms_done + 1;
      write_symbol(31);
      pulse_last;
      chk("post_rst_full", W'(o_bank_full), W'(2'b01));
      wait_reads(target);
      tick;
      chk("post_rst_drained", W'(o_bank_full), W'(0));

      set_mode(3);
      tick;
      tick;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ant_symbol_pingpong_buf.md
ANT_SYMBOL_PINGPONG_BUF -- requirements
Module: ant_symbol_pingpong_buf

Interface
REQ-001 Parameter ANT, 4: number of antenna lanes.
REQ-002 Parameter RE_NUM, 1584: REs per symbol, which is 132 PRB x 12.
REQ-003 Single clock; reset synchronous, active-high.
REQ-004 i_clk  in  1: sole clock; all logic on rising edge.
REQ-005 i_reset  in  1: synchronous active-high reset.
REQ-006 i_iq_addr  in  11: RE write index, 0..RE_NUM-1.
REQ-007 i_iq_data  in  ANT x 32: per-antenna {I[15:0], Q[15:0]}.
REQ-008 i_iq_vld  in  1: write strobe for i_iq_addr/i_iq_data.
REQ-009 i_iq_last  in  1: one-cycle pulse, current write symbol complete.
REQ-010 i_rd_ready  in  1: downstream accepts o_rd_* this cycle.
REQ-011 o_rd_data  out  ANT x 32: buffered RE data.
REQ-012 o_rd_addr  out  11: RE index of o_rd_data.
REQ-013 o_rd_vld  out  1: o_rd_* valid.
REQ-014 o_rd_last  out  1: high with the beat at o_rd_addr = RE_NUM-1.
REQ-015 o_bank_full  out  2: per-bank full flags.
REQ-016 o_overflow  out  1: sticky, a symbol was overwritten before being read.
REQ-017 o_ovf_cnt  out  16: overflow event count (see Configuration).

Function
REQ-018 Two banks of RE_NUM x (ANT*32) RAM with 1-cycle read latency; wbank selects the write bank and starts at 0.
REQ-019 When i_iq_vld=1, i_iq_data is written to bank[wbank] at i_iq_addr; writes with i_iq_addr >= RE_NUM are ignored.
REQ-020 On i_iq_last=1, the block sets o_bank_full[wbank]; if bank[~wbank] is not full, wbank toggles.
REQ-021 If bank[~wbank] is still full at i_iq_last, wbank does not toggle and o_bank_full[wbank] stays set. The next symbol overwrites that bank, o_overflow is set, and the overflow event counter increments.
REQ-022 A bank full-flag clear from the read side in the same cycle as i_iq_last counts as not full; no overflow is raised.
REQ-023 i_iq_last is honoured regardless of i_iq_vld.
REQ-024 Read FSM has states IDLE, READ, DRAIN and DONE.
REQ-025 IDLE -> READ when any o_bank_full bit is set. The FSM takes rbank = the oldest full bank; if both are full, rbank = ~wbank.
REQ-026 READ issues RAM reads at raddr 0..RE_NUM-1 through a 2-entry skid. A read is issued only when the skid can absorb it.
REQ-027 First o_rd_vld asserts 2 cycles after the IDLE->READ transition cycle when i_rd_ready=1.
REQ-028 With i_rd_ready held at 1, the block delivers one beat per cycle: RE_NUM beats in RE_NUM consecutive cycles, with no gaps.
REQ-029 When o_rd_vld=1 and i_rd_ready=0, o_rd_data, o_rd_addr and o_rd_last hold stable, and no beat is lost or duplicated.
REQ-030 After the last read is issued, READ -> DRAIN; DRAIN -> DONE when the o_rd_last beat is accepted.
REQ-031 DONE lasts 1 cycle, clears o_bank_full[rbank], then goes to IDLE.
REQ-032 The read side never reads the bank currently selected by wbank unless that bank is full.

Reset
REQ-033 On i_reset: wbank=0, FSM=IDLE, skid emptied, o_rd_vld=0, o_rd_last=0, o_rd_addr=0, o_rd_data=0, o_bank_full=0, o_overflow=0, o_ovf_cnt=0.
REQ-034 RAM contents are not cleared on reset.
REQ-035 Reset mid-symbol or mid-read discards all in-progress state; the first i_iq_last after reset completes bank 0.

Configuration
REQ-036 Macro SYMBUF_OVF_CNT_EN defined: o_ovf_cnt counts overflow events, saturating at 16'hFFFF.
REQ-037 Macro SYMBUF_OVF_CNT_EN undefined: no counter logic; o_ovf_cnt is tied to 0. o_overflow is unaffected.

Verification
REQ-038 Write 1584 REs with data = addr, then pulse i_iq_last; i_rd_ready=1 -> o_bank_full=2'b01, then 1584 beats with o_rd_addr 0..1583 and data = addr, o_rd_last on beat 1583, o_bank_full returns to 0.
REQ-039 Same write, then toggle i_rd_ready every cycle -> 1584 beats total, each address exactly once and in order, with stable outputs while stalled.
REQ-040 Three symbols written with i_rd_ready=0 -> third i_iq_last sets o_overflow=1 and o_ovf_cnt=1 (macro defined) or 0 (macro undefined); bank 1 holds symbol 3.
REQ-041 i_iq_last in the same cycle as DONE of the other bank -> no overflow, and wbank toggles.
REQ-042 Assert i_reset at read beat 700 -> o_rd_vld=0 next cycle, o_bank_full=0; a new symbol then writes bank 0 and reads back correctly.
